// File: rtl/mod_n_down_counter_pkg.sv
// Lab-wide constants shared by the counter blocks: default modulus/width and the
// reload value that the counter wraps, clamps and resets to.
package mod_n_down_counter_pkg;

    localparam int DEFAULT_MOD   = 5;
    localparam int DEFAULT_WIDTH = 3;

    function automatic int reload_of(input int mod);
        return mod - 1;
    endfunction

endpackage

// File: rtl/mod_n_down_counter_reg.sv
// Lab register cell: W-bit flop with a synchronous active-high reset to RST_VAL
// and a load enable.
module mod_n_down_counter_reg #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         enable,
    input  logic [W-1:0] in,
    output logic [W-1:0] out
);

    logic [W-1:0] r_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_q <= RST_VAL;
        end else if (enable) begin
            r_q <= in;
        end
    end

    assign out = r_q;

endmodule

// File: rtl/mod_n_down_counter.sv
// Loadable modulo-MOD down counter with terminal-count decode and a wrap pulse.
// Define MOD_N_DOWN_COUNTER_ONE_SHOT_EN to stop at 0 instead of wrapping.
module mod_n_down_counter
    import mod_n_down_counter_pkg::*;
#(
    parameter int MOD   = DEFAULT_MOD,
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] out,
    output logic             reach0,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] L_RELOAD = WIDTH'(reload_of(MOD));
    localparam logic [WIDTH:0]   L_MOD    = (WIDTH+1)'(MOD);

    generate
        if (MOD < 2 || MOD > 256 || (2 ** WIDTH) < MOD) begin : g_param_check
            $fatal(1, "mod_n_down_counter: illegal MOD=%0d / WIDTH=%0d", MOD, WIDTH);
        end
    endgenerate

    logic [WIDTH-1:0] w_out;
    logic [WIDTH-1:0] w_out_next;
    logic             w_wrap;
    logic             w_wrap_next;

    // Hold is expressed through next-state selection, so both cells are always enabled.
    always_comb begin
        w_out_next  = w_out;
        w_wrap_next = 1'b0;
        if (load) begin
            w_out_next = ({1'b0, load_value} >= L_MOD) ? L_RELOAD : load_value;
        end else if (enable) begin
            if ({1'b0, w_out} >= L_MOD) begin
                w_out_next = L_RELOAD;
            end else if (w_out == '0) begin
`ifdef MOD_N_DOWN_COUNTER_ONE_SHOT_EN
                w_out_next = w_out;
`else
                w_out_next  = L_RELOAD;
                w_wrap_next = 1'b1;
`endif
            end else begin
                w_out_next = w_out - 1'b1;
            end
        end
    end

    mod_n_down_counter_reg #(
        .W       (WIDTH),
        .RST_VAL (L_RELOAD)
    ) u_count_reg (
        .clock  (clock),
        .reset  (reset),
        .enable (1'b1),
        .in     (w_out_next),
        .out    (w_out)
    );

    mod_n_down_counter_reg #(
        .W       (1),
        .RST_VAL (1'b0)
    ) u_wrap_reg (
        .clock  (clock),
        .reset  (reset),
        .enable (1'b1),
        .in     (w_wrap_next),
        .out    (w_wrap)
    );

    assign out    = w_out;
    assign reach0 = (w_out == '0);
    assign wrap   = w_wrap;

endmodule

// File: tb/tb_mod_n_down_counter.sv
// Directed-vector bench for mod_n_down_counter (MOD=5, WIDTH=3); follows the
// one-shot variant when MOD_N_DOWN_COUNTER_ONE_SHOT_EN is defined.
module tb_mod_n_down_counter;

    localparam int MOD   = 5;
    localparam int WIDTH = 3;

    typedef struct {
        logic             rst;
        logic             ld;
        logic             en;
        logic [WIDTH-1:0] lv;
        logic [WIDTH-1:0] exp_out;
        logic             exp_r0;
        logic             exp_wrap;
    } vec_t;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             enable = 1'b0;
    logic             load = 1'b0;
    logic [WIDTH-1:0] load_value = '0;
    logic [WIDTH-1:0] out;
    logic             reach0;
    logic             wrap;

    int n_vec = 0;
    int n_err = 0;
    vec_t tbl[$];

    mod_n_down_counter #(.MOD(MOD), .WIDTH(WIDTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .load_value (load_value),
        .out        (out),
        .reach0     (reach0),
        .wrap       (wrap)
    );

    always #5 clock = ~clock;

    task automatic add(input logic rst, input logic ld, input logic en, input int lv,
                       input int eo, input logic er, input logic ew);
        vec_t v;
        v.rst = rst; v.ld = ld; v.en = en;
        v.lv = WIDTH'(lv); v.exp_out = WIDTH'(eo);
        v.exp_r0 = er; v.exp_wrap = ew;
        tbl.push_back(v);
    endtask

    task automatic step(input logic rst, input logic ld, input logic en, input logic [WIDTH-1:0] lv);
        reset = rst; load = ld; enable = en; load_value = lv;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [WIDTH-1:0] eo, input logic er, input logic ew);
        n_vec++;
        if (out !== eo || reach0 !== er || wrap !== ew) begin
            n_err++;
            $display("FAIL %s: got out=%0d reach0=%0b wrap=%0b, expected out=%0d reach0=%0b wrap=%0b",
                     name, out, reach0, wrap, eo, er, ew);
        end
    endtask

    initial begin
        int hits;
        int first_hit;

        //    rst ld en lv  out r0 wrap
        add(1, 0, 0, 0,  4, 0, 0);
`ifndef MOD_N_DOWN_COUNTER_ONE_SHOT_EN
        add(0, 0, 1, 0,  3, 0, 0);
        add(0, 0, 1, 0,  2, 0, 0);
        add(0, 0, 1, 0,  1, 0, 0);
        add(0, 0, 1, 0,  0, 1, 0);
        add(0, 0, 1, 0,  4, 0, 1);
        add(0, 0, 1, 0,  3, 0, 0);
        add(0, 0, 1, 0,  2, 0, 0);
        add(0, 0, 1, 0,  1, 0, 0);
        add(0, 0, 1, 0,  0, 1, 0);
        add(0, 0, 1, 0,  4, 0, 1);
        add(0, 0, 1, 0,  3, 0, 0);
        add(0, 1, 1, 1,  1, 0, 0);   // load beats enable
        add(0, 0, 1, 0,  0, 1, 0);
        add(0, 0, 1, 0,  4, 0, 1);
        add(0, 1, 0, 7,  4, 0, 0);   // clamp
        add(0, 1, 1, 0,  0, 1, 0);
        add(0, 0, 1, 0,  4, 0, 1);
        add(0, 0, 1, 0,  3, 0, 0);
        add(0, 0, 1, 0,  2, 0, 0);
        add(0, 0, 1, 0,  1, 0, 0);   // enable 1,0,0,1
        add(0, 0, 0, 0,  1, 0, 0);
        add(0, 0, 0, 0,  1, 0, 0);
        add(0, 0, 1, 0,  0, 1, 0);
        add(0, 0, 0, 0,  0, 1, 0);   // reach0 held while out stays 0
        add(0, 0, 1, 0,  4, 0, 1);
        add(0, 0, 1, 0,  3, 0, 0);
        add(0, 0, 1, 0,  2, 0, 0);
        add(0, 0, 1, 0,  1, 0, 0);
        add(1, 1, 1, 2,  4, 0, 0);   // reset beats load
        add(0, 1, 0, 4,  4, 0, 0);
        add(0, 0, 1, 0,  3, 0, 0);
        add(0, 1, 0, 0,  0, 1, 0);
        add(1, 0, 1, 0,  4, 0, 0);   // reset at 0 suppresses the wrap
        add(0, 1, 0, 5,  4, 0, 0);   // load_value == MOD clamps
        add(0, 0, 1, 0,  3, 0, 0);
        add(0, 1, 0, 6,  4, 0, 0);
`else
        add(0, 0, 1, 0,  3, 0, 0);
        add(0, 0, 1, 0,  2, 0, 0);
        add(0, 0, 1, 0,  1, 0, 0);
        add(0, 0, 1, 0,  0, 1, 0);
        add(0, 0, 1, 0,  0, 1, 0);
        add(0, 0, 1, 0,  0, 1, 0);
        add(0, 0, 1, 0,  0, 1, 0);
        add(0, 0, 1, 0,  0, 1, 0);
        add(0, 1, 0, 3,  3, 0, 0);
        add(0, 0, 1, 0,  2, 0, 0);
        add(0, 0, 1, 0,  1, 0, 0);
        add(0, 0, 1, 0,  0, 1, 0);
        add(0, 0, 1, 0,  0, 1, 0);
        add(0, 1, 1, 7,  4, 0, 0);
        add(1, 0, 1, 0,  4, 0, 0);
`endif

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].ld, tbl[i].en, tbl[i].lv);
            check($sformatf("vec%0d", i), tbl[i].exp_out, tbl[i].exp_r0, tbl[i].exp_wrap);
        end

        // Combinational reach0 follows a mid-cycle change of out without waiting an edge.
        step(0, 1, 0, 3'd0);
        load = 1'b0;
        #2;
        check("reach0_zero_latency", 3'd0, 1'b1, 1'b0);

`ifndef MOD_N_DOWN_COUNTER_ONE_SHOT_EN
        // Period: reach0 every MOD enabled cycles, first at cycle MOD-1.
        step(1, 0, 0, 3'd0);
        hits = 0;
        first_hit = -1;
        for (int c = 1; c <= 3 * MOD; c++) begin
            step(0, 0, 1, 3'd0);
            check($sformatf("period_c%0d", c), 3'((MOD - 1) - ((c - 1) % MOD) - 1 + ((c % MOD) == 0 ? MOD : 0)),
                  (c % MOD) == (MOD - 1), (c % MOD) == 0);
            if (reach0) begin
                hits++;
                if (first_hit < 0) first_hit = c;
            end
        end
        n_vec++;
        if (hits != 3 || first_hit != MOD - 1) begin
            n_err++;
            $display("FAIL period_summary: got hits=%0d first=%0d, expected hits=3 first=%0d",
                     hits, first_hit, MOD - 1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
